// File: rtl/gcbp_subimage_writer.sv
// Captures the vertical window of each frame's GCBP lines into a ping-pong
// sub-image BRAM and reports complete or corrupt frames to the stabiliser.
module gcbp_subimage_writer #(
  parameter int BRAM_DATA_WIDTH   = 128,
  parameter int C_SUBIMAGE_HEIGHT = 128,
  parameter int C_VERT_OFFSET     = 176,
  parameter int C_LINE_CNT_BITS   = 10
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_new_frame,
  input  logic                       i_new_line,
  input  logic [BRAM_DATA_WIDTH-1:0] i_gcbp_line,
  input  logic                       i_gcbp_line_valid,
  input  logic [1:0]                 i_hori_subimage_cnt,
  output logic                       o_bram_we,
  output logic [9:0]                 o_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] o_bram_wdata,
  output logic                       o_frame_ready,
  output logic                       o_ready_bank,
  output logic                       o_frame_error
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_CAPTURE, S_POST} state_t;

  localparam logic [C_LINE_CNT_BITS-1:0] FIRST_LINE = C_LINE_CNT_BITS'(C_VERT_OFFSET);
  localparam logic [C_LINE_CNT_BITS-1:0] END_LINE   = C_LINE_CNT_BITS'(C_VERT_OFFSET + C_SUBIMAGE_HEIGHT);
  localparam logic [C_LINE_CNT_BITS-1:0] CNT_MAX    = '1;
  localparam state_t FRAME_START_STATE = (C_VERT_OFFSET == 0) ? S_CAPTURE : S_PRE;

  state_t                     state, state_next;
  logic [C_LINE_CNT_BITS-1:0] line_cnt, line_cnt_next;
  logic [6:0]                 row;
  logic [3:0]                 mask, mask_next, mask_seen, idx_bit;
  logic                       err, err_next, err_seen;
  logic                       bank;
  logic                       capturing, line_step, valid_acc, dup, window_done, abort;
  logic                       we_next, ready_next, error_next;

  always_comb begin
    line_cnt_next = line_cnt;
    if (i_new_frame) begin
      line_cnt_next = '0;
    end else if (i_new_line && (line_cnt != CNT_MAX)) begin
      line_cnt_next = line_cnt + 1'b1;
    end
  end

  // A valid coincident with i_new_line still belongs to the ending line, so
  // the line check and frame verdict look at the mask including that write.
  assign line_step   = i_new_line & ~i_new_frame;
  assign capturing   = (state == S_CAPTURE);
  assign valid_acc   = capturing & i_gcbp_line_valid;
  assign idx_bit     = 4'b0001 << i_hori_subimage_cnt;
  assign dup         = valid_acc & (|(mask & idx_bit));
  assign mask_seen   = valid_acc ? (mask | idx_bit) : mask;
  assign err_seen    = err | dup | (line_step & (mask_seen != 4'hF));
  assign window_done = capturing & line_step & (line_cnt_next == END_LINE);
  assign abort       = capturing & i_new_frame;
  assign row         = 7'(line_cnt - FIRST_LINE);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state    <= S_IDLE;
      line_cnt <= '0;
      mask     <= 4'h0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      line_cnt <= line_cnt_next;
      mask     <= mask_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_POST: begin
        if (i_new_frame) state_next = FRAME_START_STATE;
      end
      S_PRE: begin
        if (i_new_frame) state_next = FRAME_START_STATE;
        else if (line_step && (line_cnt_next == FIRST_LINE)) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (i_new_frame) state_next = FRAME_START_STATE;
        else if (window_done) state_next = S_POST;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Mask and error flag only live inside a capture window; an abort or the
  // window end wipes them.
  always_comb begin
    we_next    = valid_acc & ~dup;
    ready_next = window_done & ~err_seen;
    error_next = window_done & err_seen;
    mask_next  = 4'h0;
    err_next   = 1'b0;
    if (capturing && !abort && !window_done) begin
      mask_next = line_step ? 4'h0 : mask_seen;
      err_next  = err_seen;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      bank          <= 1'b0;
      o_bram_we     <= 1'b0;
      o_bram_addr   <= '0;
      o_bram_wdata  <= '0;
      o_frame_ready <= 1'b0;
      o_ready_bank  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_bram_we     <= we_next;
      o_frame_ready <= ready_next;
      o_frame_error <= error_next;
      if (we_next) begin
        o_bram_addr  <= {bank, i_hori_subimage_cnt, row};
        o_bram_wdata <= i_gcbp_line;
      end
      if (ready_next) begin
        o_ready_bank <= bank;
        bank         <= ~bank;
      end
    end
  end

endmodule

// File: tb/tb_gcbp_subimage_writer.sv
// Randomised frame-level bench for gcbp_subimage_writer with a queue-based
// expectation model of writes and frame verdicts.
`timescale 1ns/1ps
module tb_gcbp_subimage_writer;

  localparam int FIRST = 176;
  localparam int LAST  = 303;
  localparam int LINES = 480;
  localparam int NONE  = -1;

  logic         i_clk = 1'b0;
  logic         i_resetn = 1'b0;
  logic         i_new_frame, i_new_line, i_gcbp_line_valid;
  logic [127:0] i_gcbp_line;
  logic [1:0]   i_hori_subimage_cnt;
  logic         o_bram_we, o_frame_ready, o_ready_bank, o_frame_error;
  logic [9:0]   o_bram_addr;
  logic [127:0] o_bram_wdata;

  gcbp_subimage_writer dut (
    .i_clk               (i_clk),
    .i_resetn            (i_resetn),
    .i_new_frame         (i_new_frame),
    .i_new_line          (i_new_line),
    .i_gcbp_line         (i_gcbp_line),
    .i_gcbp_line_valid   (i_gcbp_line_valid),
    .i_hori_subimage_cnt (i_hori_subimage_cnt),
    .o_bram_we           (o_bram_we),
    .o_bram_addr         (o_bram_addr),
    .o_bram_wdata        (o_bram_wdata),
    .o_frame_ready       (o_frame_ready),
    .o_ready_bank        (o_ready_bank),
    .o_frame_error       (o_frame_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int edge_no; logic [9:0] addr; logic [127:0] data; } wr_t;
  typedef struct { int edge_no; bit is_err; bit bank; } ev_t;
  typedef struct { logic [1:0] idx; logic [127:0] data; } item_t;

  wr_t  wr_q[$];
  ev_t  ev_q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count, rdy_count, err_count;
  logic [9:0] addr_min, addr_max;
  logic obs_bank;
  bit   m_bank = 1'b0;
  logic [3:0] m_mask = 4'h0;
  bit   m_err = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_idle();
    i_new_frame = 1'b0;
    i_new_line = 1'b0;
    i_gcbp_line_valid = 1'b0;
    i_gcbp_line = '0;
    i_hori_subimage_cnt = 2'd0;
  endtask

  task automatic drive_item(input item_t it);
    i_gcbp_line_valid = 1'b1;
    i_gcbp_line = it.data;
    i_hori_subimage_cnt = it.idx;
  endtask

  // Model: a delivered sub-image line is stored once per captured row; any
  // repeat or gap poisons the frame.
  task automatic model_item(input int line, input item_t it, input int edge_no);
    wr_t w;
    if (line >= FIRST && line <= LAST) begin
      if (m_mask[it.idx]) begin
        m_err = 1'b1;
      end else begin
        m_mask[it.idx] = 1'b1;
        w.edge_no = edge_no;
        w.addr = {m_bank, it.idx, 7'(line - FIRST)};
        w.data = it.data;
        wr_q.push_back(w);
      end
    end
  endtask

  task automatic model_line_end(input int line, input int edge_no);
    ev_t e;
    if (line >= FIRST && line <= LAST) begin
      if (m_mask != 4'hF) m_err = 1'b1;
      m_mask = 4'h0;
      if (line == LAST) begin
        e.edge_no = edge_no;
        e.is_err = m_err;
        e.bank = m_bank;
        ev_q.push_back(e);
        if (!m_err) m_bank = ~m_bank;
        m_err = 1'b0;
      end
    end
  endtask

  initial begin
    bit   exp_we, exp_ev, exp_is_err, exp_bank;
    forever begin
      @(posedge i_clk);
      #1;
      edge_cnt++;
      exp_we = (wr_q.size() > 0) && (wr_q[0].edge_no == edge_cnt);
      checkOutput("bram_we", o_bram_we, exp_we);
      if (exp_we) begin
        checkOutput("bram_addr", o_bram_addr, wr_q[0].addr);
        checkOutput("bram_wdata", o_bram_wdata, wr_q[0].data);
        void'(wr_q.pop_front());
      end
      exp_ev = (ev_q.size() > 0) && (ev_q[0].edge_no == edge_cnt);
      exp_is_err = exp_ev ? ev_q[0].is_err : 1'b0;
      exp_bank = exp_ev ? ev_q[0].bank : 1'b0;
      checkOutput("frame_ready", o_frame_ready, exp_ev && !exp_is_err);
      checkOutput("frame_error", o_frame_error, exp_ev && exp_is_err);
      if (exp_ev && !exp_is_err) checkOutput("ready_bank", o_ready_bank, exp_bank);
      if (exp_ev) void'(ev_q.pop_front());
      if (o_bram_we) begin
        wr_count++;
        if (o_bram_addr < addr_min) addr_min = o_bram_addr;
        if (o_bram_addr > addr_max) addr_max = o_bram_addr;
      end
      if (o_frame_ready) begin
        rdy_count++;
        obs_bank = o_ready_bank;
      end
      if (o_frame_error) err_count++;
    end
  end

  task automatic reset_mid_line();
    @(posedge i_clk);
    #2;
    i_resetn = 1'b0;
    drive_idle();
    #1;
    checkOutput("rst_async_we", o_bram_we, 0);
    checkOutput("rst_async_addr", o_bram_addr, 0);
    checkOutput("rst_async_wdata", o_bram_wdata, 0);
    checkOutput("rst_async_ready", o_frame_ready, 0);
    checkOutput("rst_async_error", o_frame_error, 0);
    checkOutput("rst_async_bank", o_ready_bank, 0);
    wr_q.delete();
    ev_q.delete();
    m_bank = 1'b0;
    m_mask = 4'h0;
    m_err = 1'b0;
    repeat (3) @(negedge i_clk);
    i_resetn = 1'b1;
  endtask

  // One frame: every line carries a shuffled set of sub-images, sometimes with
  // the last one slipped onto the next line's i_new_line cycle.
  task automatic applyStimulus(input int abort_line, input int missing_line, input int dup_line, input int reset_line);
    item_t items[$];
    item_t it, tmp, pend;
    bit    have_pend = 1'b0;
    int    j;
    for (int ln = 0; ln < LINES; ln++) begin
      if (ln == abort_line) break;
      items.delete();
      for (int k = 0; k < 4; k++) begin
        it.idx = 2'(k);
        it.data = rand_line();
        items.push_back(it);
      end
      for (int k = 3; k > 0; k--) begin
        j = int'($urandom_range(0, k));
        tmp = items[k];
        items[k] = items[j];
        items[j] = tmp;
      end
      if (ln == missing_line) begin
        for (int k = 0; k < items.size(); k++) begin
          if (items[k].idx == 2'd2) begin
            items.delete(k);
            break;
          end
        end
      end
      if (ln == dup_line) begin
        it.idx = 2'd2;
        it.data = rand_line();
        items.push_back(it);
      end
      @(negedge i_clk);
      drive_idle();
      i_new_line = 1'b1;
      i_new_frame = (ln == 0);
      if (ln == 0) begin
        m_mask = 4'h0;
        m_err = 1'b0;
      end
      if (have_pend) begin
        drive_item(pend);
        model_item(ln - 1, pend, edge_cnt + 1);
        have_pend = 1'b0;
      end
      if (ln > 0) model_line_end(ln - 1, edge_cnt + 1);
      if ((ln + 1 < LINES) && (ln + 1 != abort_line) && (ln + 1 != reset_line) && ($urandom_range(0, 3) == 0)) begin
        pend = items.pop_back();
        have_pend = 1'b1;
      end
      for (int k = 0; k < items.size(); k++) begin
        if (ln == reset_line && k == 1) begin
          reset_mid_line();
          return;
        end
        @(negedge i_clk);
        drive_idle();
        drive_item(items[k]);
        model_item(ln, items[k], edge_cnt + 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge i_clk);
        drive_idle();
      end
    end
    @(negedge i_clk);
    drive_idle();
  endtask

  task automatic runFrame(input string name, input int abort_line, input int missing_line, input int dup_line,
                          input int reset_line, input int exp_wr, input int exp_min, input int exp_max,
                          input int exp_rdy, input int exp_err, input int exp_bank);
    wr_count = 0;
    rdy_count = 0;
    err_count = 0;
    addr_min = '1;
    addr_max = '0;
    applyStimulus(abort_line, missing_line, dup_line, reset_line);
    @(posedge i_clk);
    #2;
    checkOutput({name, "_writes"}, wr_count, exp_wr);
    if (exp_min >= 0) checkOutput({name, "_addr_min"}, addr_min, exp_min);
    if (exp_max >= 0) checkOutput({name, "_addr_max"}, addr_max, exp_max);
    checkOutput({name, "_ready_pulses"}, rdy_count, exp_rdy);
    checkOutput({name, "_error_pulses"}, err_count, exp_err);
    if (exp_rdy > 0) checkOutput({name, "_ready_bank"}, obs_bank, exp_bank);
    $display("[TB] frame %s done", name);
  endtask

  initial begin
    drive_idle();
    i_resetn = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_we", o_bram_we, 0);
    checkOutput("reset_addr", o_bram_addr, 0);
    checkOutput("reset_ready", o_frame_ready, 0);
    checkOutput("reset_error", o_frame_error, 0);
    checkOutput("reset_bank", o_ready_bank, 0);
    i_resetn = 1'b1;
    repeat (2) @(negedge i_clk);

    runFrame("clean1",  NONE, NONE, NONE, NONE, 512, 'h000, 'h1FF, 1, 0, 0);
    runFrame("clean2",  NONE, NONE, NONE, NONE, 512, 'h200, 'h3FF, 1, 0, 1);
    runFrame("clean3",  NONE, NONE, NONE, NONE, 512, 'h000, 'h1FF, 1, 0, 0);
    runFrame("missing", NONE, 200,  NONE, NONE, 511, 'h200, 'h3FF, 0, 1, 0);
    runFrame("rewrite", NONE, NONE, NONE, NONE, 512, 'h200, 'h3FF, 1, 0, 1);
    runFrame("dup",     NONE, NONE, 181,  NONE, 512, 'h000, 'h1FF, 0, 1, 0);
    runFrame("short",   250,  NONE, NONE, NONE, 296, 'h000, 'h1C9, 0, 0, 0);
    runFrame("after",   NONE, NONE, NONE, NONE, 512, 'h000, 'h1FF, 1, 0, 0);
    runFrame("reset",   NONE, NONE, NONE, 236,  241, 'h200, NONE,  0, 0, 0);
    runFrame("restart", NONE, NONE, NONE, NONE, 512, 'h000, 'h1FF, 1, 0, 0);

    repeat (5) @(negedge i_clk);
    checkOutput("writes_drained", wr_q.size(), 0);
    checkOutput("events_drained", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcbp_subimage_writer.md
Name: gcbp_subimage_writer

Overview:
- Downstream of the GCBP line generator. Consumes each completed 128-bit bit-plane sub-image line and its 2-bit horizontal sub-image index.
- Writes the line into a ping-pong sub-image BRAM (two banks x 4 sub-images x 128 rows).
- Selects the vertical capture window inside the 480-line frame, checks that every captured line delivered all four sub-images, and announces completed or corrupt frames to the stabilisation core.

Parameters:
- BRAM_DATA_WIDTH, 128, width of one GCBP line / BRAM word.
- C_SUBIMAGE_HEIGHT, 128, rows captured per sub-image. Power of two; fixed at 128 for a 7-bit row field.
- C_VERT_OFFSET, 176, frame line index of the first captured row. Equals (480-128)/2.
- C_LINE_CNT_BITS, 10, width of the frame line counter.

Ports:
- i_clk  in  1  system clock
- i_resetn  in  1  reset, asynchronous, active-low
- i_new_frame  in  1  1-cycle pulse, coincident with the i_new_line of frame line 0
- i_new_line  in  1  1-cycle pulse at the start of every line
- i_gcbp_line  in  128  GCBP line data
- i_gcbp_line_valid  in  1  i_gcbp_line is complete this cycle
- i_hori_subimage_cnt  in  2  sub-image index of i_gcbp_line
- o_bram_we  out  1  BRAM write enable
- o_bram_addr  out  10  {bank, sub-image[1:0], row[6:0]}
- o_bram_wdata  out  128  BRAM write data
- o_frame_ready  out  1  1-cycle pulse: bank o_ready_bank holds a complete frame
- o_ready_bank  out  1  bank most recently completed
- o_frame_error  out  1  1-cycle pulse: capture window finished with missing or duplicate lines

Behaviour:
- Reset (async assert, synchronous release): all outputs 0, write bank 0, line counter 0, state S_IDLE, line mask 0, error flag 0.

Line counter:
- On i_new_frame the counter loads 0; this has priority over i_new_line.
- On i_new_line alone it increments, saturating at 1023.
- Row = line_cnt - C_VERT_OFFSET, truncated to 7 bits.

States:
- S_IDLE: wait for i_new_frame, then go to S_PRE. When C_VERT_OFFSET = 0, go straight to S_CAPTURE.
- S_PRE: enter S_CAPTURE on the i_new_line that makes line_cnt reach C_VERT_OFFSET.
- S_CAPTURE: accept writes. Leave on the i_new_line that moves line_cnt past C_VERT_OFFSET+C_SUBIMAGE_HEIGHT-1, going to S_POST. That cycle pulses exactly one of o_frame_ready or o_frame_error.
- S_POST: wait for i_new_frame, then go to S_PRE (or S_CAPTURE when C_VERT_OFFSET = 0).

Writes:
- Only in S_CAPTURE with i_gcbp_line_valid = 1.
- Latency 1 cycle: o_bram_we, o_bram_addr and o_bram_wdata are registered and valid the cycle after the valid strobe.
- o_bram_we is 0 in every other cycle.

Line mask:
- 4-bit mask; bit i_hori_subimage_cnt is set on each accepted write.
- A valid whose mask bit is already set is a duplicate: the write is suppressed and the error flag is set.
- At each i_new_line in S_CAPTURE, a mask other than 4'hF sets the error flag. The mask then clears.
- A valid coincident with i_new_line belongs to the ending line: it is written with the old row and checked before the mask clears.

Frame end (S_CAPTURE to S_POST):
- Error flag clear: pulse o_frame_ready, set o_ready_bank to the write bank, then toggle the write bank.
- Error flag set: pulse o_frame_error and keep the write bank, so the partial bank is overwritten.
- In both cases the error flag clears.

i_new_frame in S_CAPTURE (short frame):
- Abort: no ready or error pulse, bank not toggled, mask and error flag cleared.
- Restart at line 0 in S_PRE.

Other rules:
- Valid strobes outside S_CAPTURE are ignored and do not touch the mask.
- Reset mid-capture discards everything; the bank returns to 0.

Test Plan:
1. Reset release, then a full frame with 4 valids per line at subimage indices 0..3 → 512 writes. Addresses 0x000..0x1FF, row = line-176. o_frame_ready pulses on the line-304 i_new_line, with o_ready_bank = 0.
2. Second clean frame → writes to addresses 0x200..0x3FF, o_ready_bank = 1. Third frame writes bank 0 again.
3. Frame where line 200 delivers only subimages 0,1,3 → o_frame_error pulses at window end, no o_frame_ready. The next frame rewrites the same bank.
4. Duplicate subimage 2 on row 5 → the second write is suppressed (only one o_bram_we with addr {b,2,5}), then o_frame_error at window end.
5. i_new_frame at line 250 mid-capture → no pulses, bank unchanged. The next full frame completes to the same bank, and o_frame_ready fires.
6. Valids during lines 0..175 and 304..479, plus i_resetn low at row 60 → no writes outside the window. All outputs go to 0 immediately on reset, and the bank returns to 0 on restart.
